// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and encodings for the unified memory port arbiter.
`ifndef WIDTH
`define WIDTH 32
`endif

package mem_port_arbiter_pkg;
   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   localparam logic       OWN_IF  = 1'b0;
   localparam logic       OWN_DM  = 1'b1;
   localparam logic [3:0] BE_FULL = 4'hF;
endpackage

// File: rtl/mem_port_arbiter_mux32.sv
// 2:1 word multiplexer steering either the fetch or the data-side word onto the memory port.
`ifndef WIDTH
`define WIDTH 32
`endif

module mem_port_arbiter_mux32 (
   input  logic              i_sel,
   input  logic [`WIDTH-1:0] i_d0,
   input  logic [`WIDTH-1:0] i_d1,
   output logic [`WIDTH-1:0] o_y
);
   assign o_y = i_sel ? i_d1 : i_d0;
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one non-pipelined memory port between instruction fetch and data access.
// Optional macro ARB_FAIRNESS_EN bounds consecutive DM grants while a fetch is waiting.
`ifndef WIDTH
`define WIDTH 32
`endif

module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int LAT           = 1,
   parameter int DM_MAX_CONSEC = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [`WIDTH-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [3:0]        dm_be,
   input  logic [`WIDTH-1:0] dm_addr,
   input  logic [`WIDTH-1:0] dm_wdata,
   output logic              dm_gnt,
   output logic              dm_rvalid,
   output logic [`WIDTH-1:0] rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [3:0]        mem_be,
   output logic              mem_sel,
   output logic [`WIDTH-1:0] mem_addr,
   output logic [`WIDTH-1:0] mem_wdata,
   input  logic [`WIDTH-1:0] mem_rdata,
   output logic              stall_if
);
   localparam int CNT_W = $clog2(LAT + 1);

   arb_state_t        r_state, w_state_next;
   logic [CNT_W-1:0]  r_cnt, w_cnt_next;
   // The owner flag is also the registered mux select held between grants.
   logic              r_owner;
   logic [`WIDTH-1:0] r_rdata;
   logic              r_if_rvalid, r_dm_rvalid;
   logic              w_grant_dm, w_grant_if, w_grant, w_done, w_sel, w_if_wins;

`ifdef ARB_FAIRNESS_EN
   localparam int CONS_W = $clog2(DM_MAX_CONSEC + 1);
   logic [CONS_W-1:0] r_consec;

   assign w_if_wins = if_req & dm_req & (r_consec == CONS_W'(DM_MAX_CONSEC));

   always_ff @(posedge clk) begin
      if (rst || !if_req || w_grant_if) begin
         r_consec <= '0;
      end else if (w_grant_dm && (r_consec != CONS_W'(DM_MAX_CONSEC))) begin
         r_consec <= r_consec + CONS_W'(1);
      end
   end
`else
   assign w_if_wins = 1'b0;
`endif

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_grant_dm   = 1'b0;
      w_grant_if   = 1'b0;
      w_done       = 1'b0;
      case (r_state)
         IDLE: begin
            // DM normally wins so the MEM stage can never be blocked by fetches.
            w_grant_dm = dm_req & ~w_if_wins & ~rst;
            w_grant_if = if_req & ~w_grant_dm & ~rst;
            if (w_grant_dm || w_grant_if) begin
               w_state_next = BUSY;
               w_cnt_next   = CNT_W'(LAT);
            end
         end
         BUSY: begin
            w_cnt_next = r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
               w_done       = 1'b1;
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   assign w_grant = w_grant_dm | w_grant_if;
   assign w_sel   = w_grant ? w_grant_dm : r_owner;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_owner     <= OWN_IF;
         r_rdata     <= '0;
         r_if_rvalid <= 1'b0;
         r_dm_rvalid <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_cnt       <= w_cnt_next;
         if (w_grant) begin
            r_owner <= w_grant_dm ? OWN_DM : OWN_IF;
         end
         if (w_done) begin
            r_rdata <= mem_rdata;
         end
         r_if_rvalid <= w_done & (r_owner == OWN_IF);
         r_dm_rvalid <= w_done & (r_owner == OWN_DM);
      end
   end

   mem_port_arbiter_mux32 u_addr_mux (
      .i_sel (w_sel),
      .i_d0  (if_addr),
      .i_d1  (dm_addr),
      .o_y   (mem_addr)
   );

   mem_port_arbiter_mux32 u_wdata_mux (
      .i_sel (w_sel),
      .i_d0  ({`WIDTH{1'b0}}),
      .i_d1  (dm_wdata),
      .o_y   (mem_wdata)
   );

   assign if_gnt    = w_grant_if;
   assign dm_gnt    = w_grant_dm;
   assign mem_en    = w_grant;
   assign mem_we    = w_grant_dm & dm_we;
   assign mem_be    = (w_grant_dm && dm_we) ? dm_be : (w_grant ? BE_FULL : 4'h0);
   assign mem_sel   = w_sel;
   assign stall_if  = if_req & ~w_grant_if;
   assign if_rvalid = r_if_rvalid;
   assign dm_rvalid = r_dm_rvalid;
   assign rdata     = r_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances with LAT = 1, 2, 3 share one clock.
// Fairness expectations follow the ARB_FAIRNESS_EN macro of the build.
module tb_mem_port_arbiter;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst[3];
   logic        if_req[3];
   logic [31:0] if_addr[3];
   logic        if_gnt[3];
   logic        if_rvalid[3];
   logic        dm_req[3];
   logic        dm_we[3];
   logic [3:0]  dm_be[3];
   logic [31:0] dm_addr[3];
   logic [31:0] dm_wdata[3];
   logic        dm_gnt[3];
   logic        dm_rvalid[3];
   logic [31:0] rdata[3];
   logic        mem_en[3];
   logic        mem_we[3];
   logic [3:0]  mem_be[3];
   logic        mem_sel[3];
   logic [31:0] mem_addr[3];
   logic [31:0] mem_wdata[3];
   logic [31:0] mem_rdata[3];
   logic        stall_if[3];

   function automatic logic [31:0] memf(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_dut
         logic [31:0] m_addr = 32'h0;
         int          m_age  = 0;

         mem_port_arbiter #(.LAT(gi + 1), .DM_MAX_CONSEC(4)) u_dut (
            .clk       (clk),
            .rst       (rst[gi]),
            .if_req    (if_req[gi]),
            .if_addr   (if_addr[gi]),
            .if_gnt    (if_gnt[gi]),
            .if_rvalid (if_rvalid[gi]),
            .dm_req    (dm_req[gi]),
            .dm_we     (dm_we[gi]),
            .dm_be     (dm_be[gi]),
            .dm_addr   (dm_addr[gi]),
            .dm_wdata  (dm_wdata[gi]),
            .dm_gnt    (dm_gnt[gi]),
            .dm_rvalid (dm_rvalid[gi]),
            .rdata     (rdata[gi]),
            .mem_en    (mem_en[gi]),
            .mem_we    (mem_we[gi]),
            .mem_be    (mem_be[gi]),
            .mem_sel   (mem_sel[gi]),
            .mem_addr  (mem_addr[gi]),
            .mem_wdata (mem_wdata[gi]),
            .mem_rdata (mem_rdata[gi]),
            .stall_if  (stall_if[gi])
         );

         // Memory whose read data is valid exactly LAT cycles after the strobe.
         always @(posedge clk) begin
            if (mem_en[gi]) begin
               m_addr <= mem_addr[gi];
               m_age  <= 1;
            end else if (m_age != 0) begin
               m_age <= m_age + 1;
            end
         end
         assign mem_rdata[gi] = (m_age == gi + 1) ? memf(m_addr) : 32'hBAD0_BAD0;
      end
   endgenerate

   typedef struct {
      logic        if_req;
      logic [31:0] if_addr;
      logic        dm_req;
      logic        dm_we;
      logic [3:0]  dm_be;
      logic [31:0] dm_addr;
      logic [31:0] dm_wdata;
      logic [11:0] e_ctrl;   // if_gnt,dm_gnt,if_rv,dm_rv,en,we,be[3:0],sel,stall
      logic        chk_bus;
      logic [31:0] e_addr;
      logic [31:0] e_wdata;
      logic        chk_rd;
      logic [31:0] e_rdata;
   } vec_t;

   localparam int NV = 13;
   vec_t tbl[NV];

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   logic [11:0] act_ctrl;
   logic        fair;
   logic        exp_if;

   initial begin
`ifdef ARB_FAIRNESS_EN
      fair = 1'b1;
`else
      fair = 1'b0;
`endif
      for (int i = 0; i < 3; i++) begin
         rst[i] = 1'b1; if_req[i] = 1'b0; if_addr[i] = 32'h0; dm_req[i] = 1'b0;
         dm_we[i] = 1'b0; dm_be[i] = 4'h0; dm_addr[i] = 32'h0; dm_wdata[i] = 32'h0;
      end

      tbl[0]  = '{1'b0, 32'h0,   1'b0, 1'b0, 4'h0,    32'h0,    32'h0,        12'b0_0_0_0_0_0_0000_0_0, 1'b0, 32'h0,    32'h0,        1'b1, 32'h0};
      tbl[1]  = '{1'b1, 32'h100, 1'b0, 1'b0, 4'h0,    32'h0,    32'h0,        12'b1_0_0_0_1_0_1111_0_0, 1'b1, 32'h100,  32'h0,        1'b0, 32'h0};
      tbl[2]  = '{1'b0, 32'h0,   1'b0, 1'b0, 4'h0,    32'h0,    32'h0,        12'b0_0_0_0_0_0_0000_0_0, 1'b0, 32'h0,    32'h0,        1'b0, 32'h0};
      tbl[3]  = '{1'b0, 32'h0,   1'b0, 1'b0, 4'h0,    32'h0,    32'h0,        12'b0_0_1_0_0_0_0000_0_0, 1'b0, 32'h0,    32'h0,        1'b1, memf(32'h100)};
      tbl[4]  = '{1'b1, 32'h104, 1'b1, 1'b0, 4'h0,    32'h2000, 32'h1111_2222, 12'b0_1_0_0_1_0_1111_1_1, 1'b1, 32'h2000, 32'h1111_2222, 1'b0, 32'h0};
      tbl[5]  = '{1'b1, 32'h104, 1'b0, 1'b0, 4'h0,    32'h0,    32'h0,        12'b0_0_0_0_0_0_0000_1_1, 1'b0, 32'h0,    32'h0,        1'b0, 32'h0};
      tbl[6]  = '{1'b1, 32'h104, 1'b0, 1'b0, 4'h0,    32'h0,    32'h0,        12'b1_0_0_1_1_0_1111_0_0, 1'b1, 32'h104,  32'h0,        1'b1, memf(32'h2000)};
      tbl[7]  = '{1'b0, 32'h0,   1'b0, 1'b0, 4'h0,    32'h0,    32'h0,        12'b0_0_0_0_0_0_0000_0_0, 1'b0, 32'h0,    32'h0,        1'b0, 32'h0};
      tbl[8]  = '{1'b0, 32'h0,   1'b0, 1'b0, 4'h0,    32'h0,    32'h0,        12'b0_0_1_0_0_0_0000_0_0, 1'b0, 32'h0,    32'h0,        1'b1, memf(32'h104)};
      tbl[9]  = '{1'b0, 32'h0,   1'b1, 1'b1, 4'b0011, 32'h3000, 32'hDEAD_BEEF, 12'b0_1_0_0_1_1_0011_1_0, 1'b1, 32'h3000, 32'hDEAD_BEEF, 1'b0, 32'h0};
      tbl[10] = '{1'b0, 32'h0,   1'b0, 1'b0, 4'h0,    32'h0,    32'h0,        12'b0_0_0_0_0_0_0000_1_0, 1'b0, 32'h0,    32'h0,        1'b0, 32'h0};
      tbl[11] = '{1'b0, 32'h0,   1'b0, 1'b0, 4'h0,    32'h0,    32'h0,        12'b0_0_0_1_0_0_0000_1_0, 1'b0, 32'h0,    32'h0,        1'b0, 32'h0};
      tbl[12] = '{1'b0, 32'h0,   1'b0, 1'b0, 4'h0,    32'h0,    32'h0,        12'b0_0_0_0_0_0_0000_1_0, 1'b0, 32'h0,    32'h0,        1'b0, 32'h0};

      next_cycle();
      next_cycle();
      for (int i = 0; i < 3; i++) rst[i] = 1'b0;

      // Vector table on the LAT=1 instance: reset state, fetch, collision, store.
      for (int i = 0; i < NV; i++) begin
         if_req[0]  = tbl[i].if_req;  if_addr[0] = tbl[i].if_addr;
         dm_req[0]  = tbl[i].dm_req;  dm_we[0]   = tbl[i].dm_we;   dm_be[0] = tbl[i].dm_be;
         dm_addr[0] = tbl[i].dm_addr; dm_wdata[0] = tbl[i].dm_wdata;
         @(negedge clk);
         act_ctrl = {if_gnt[0], dm_gnt[0], if_rvalid[0], dm_rvalid[0], mem_en[0], mem_we[0],
                     tbl[i].e_ctrl[7] ? mem_be[0] : 4'h0, mem_sel[0], stall_if[0]};
         chk($sformatf("ctrl row %0d", i), 64'(act_ctrl), 64'(tbl[i].e_ctrl));
         if (tbl[i].chk_bus) begin
            chk($sformatf("mem_addr row %0d", i), 64'(mem_addr[0]), 64'(tbl[i].e_addr));
            chk($sformatf("mem_wdata row %0d", i), 64'(mem_wdata[0]), 64'(tbl[i].e_wdata));
         end
         if (tbl[i].chk_rd) begin
            chk($sformatf("rdata row %0d", i), 64'(rdata[0]), 64'(tbl[i].e_rdata));
         end
         next_cycle();
      end

      // LAT=3: one complete fetch, then reset while cnt==2 of a second fetch.
      if_req[2] = 1'b1; if_addr[2] = 32'h480;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk($sformatf("lat3 if_rvalid k=%0d", k), 64'(if_rvalid[2]), 64'(k == 4));
         if (k == 4) chk("lat3 rdata", 64'(rdata[2]), 64'(memf(32'h480)));
         next_cycle();
         if_req[2] = 1'b0;
      end
      if_req[2] = 1'b1; if_addr[2] = 32'h500;
      @(negedge clk);
      chk("rst seq if_gnt", 64'(if_gnt[2]), 64'd1);
      next_cycle();
      if_req[2] = 1'b0;
      next_cycle();
      rst[2] = 1'b1;
      next_cycle();
      rst[2] = 1'b0;
      @(negedge clk);
      chk("post-rst outputs", 64'({if_gnt[2], dm_gnt[2], if_rvalid[2], dm_rvalid[2], mem_en[2],
                                   mem_we[2], mem_sel[2], stall_if[2]}), 64'd0);
      chk("post-rst rdata", 64'(rdata[2]), 64'd0);
      for (int k = 0; k < 6; k++) begin
         next_cycle();
         @(negedge clk);
         chk($sformatf("post-rst no rvalid k=%0d", k), 64'(if_rvalid[2] | dm_rvalid[2]), 64'd0);
      end
      next_cycle();

      // LAT=2 back-to-back fetches: grants every third cycle, rvalid with the next grant.
      for (int k = 0; k < 10; k++) begin
         if_req[1]  = 1'b1;
         if_addr[1] = 32'h400 + 32'(4 * ((k + 2) / 3));
         @(negedge clk);
         chk($sformatf("b2b if_gnt k=%0d", k), 64'(if_gnt[1]), 64'((k % 3) == 0));
         chk($sformatf("b2b if_rvalid k=%0d", k), 64'(if_rvalid[1]), 64'((k > 0) && ((k % 3) == 0)));
         if ((k > 0) && ((k % 3) == 0)) begin
            chk($sformatf("b2b rdata k=%0d", k), 64'(rdata[1]), 64'(memf(32'h400 + 32'(4 * (k / 3 - 1)))));
         end
         next_cycle();
      end
      if_req[1] = 1'b0;

      // Both requesters held on the LAT=1 instance: DM priority, optionally bounded.
      for (int k = 0; k < 12; k++) begin
         if_req[0] = 1'b1; if_addr[0] = 32'h600;
         dm_req[0] = 1'b1; dm_we[0] = 1'b0; dm_addr[0] = 32'h2400;
         @(negedge clk);
         exp_if = fair && ((k / 2) % 5 == 4);
         chk($sformatf("fair gnt k=%0d", k), 64'({if_gnt[0], dm_gnt[0]}),
             64'((k % 2 == 0) ? {exp_if, ~exp_if} : 2'b00));
         next_cycle();
      end
      if_req[0] = 1'b0;
      dm_req[0] = 1'b0;
      next_cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
